// File: rtl/cmp_pkg.sv
// Shared definitions for the nibble-serial compare arbiter: FSM encoding and widths.
package cmp_pkg;
   localparam int NREQ  = 2;
   localparam int NIB_W = 4;
   localparam int OP_W  = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HI   = 2'd1,
      ST_LO   = 2'd2,
      ST_RESP = 2'd3
   } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: the pointer only matters when both requesters are valid.
module rr_arb2
   import cmp_pkg::*;
(
   input  logic [NREQ-1:0] i_valid,
   input  logic            i_ptr,
   output logic [NREQ-1:0] o_grant
);
   always_comb begin
      o_grant = i_valid;
      if (&i_valid) begin
         o_grant = i_ptr ? 2'b10 : 2'b01;
      end
   end
endmodule

// File: rtl/cmp_arbiter.sv
// Arbitrates two 8-bit equality requests onto one external 4-bit comparator,
// checking the high nibble first and optionally skipping the low nibble on mismatch.
module cmp_arbiter
   import cmp_pkg::*;
#(
   parameter bit EARLY_OUT = 1'b1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req0_valid,
   input  logic [OP_W-1:0]  req0_a,
   input  logic [OP_W-1:0]  req0_b,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [OP_W-1:0]  req1_a,
   input  logic [OP_W-1:0]  req1_b,
   output logic             req1_ready,
   output logic [NIB_W-1:0] cmp_a,
   output logic [NIB_W-1:0] cmp_b,
   input  logic             cmp_status,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic             rsp_eq,
   input  logic             rsp_ready
);
   state_t           r_state;
   logic             r_ptr;
   logic             r_id;
   logic             r_hi_eq;
   logic [NIB_W-1:0] r_lo_a;
   logic [NIB_W-1:0] r_lo_b;
   logic [NIB_W-1:0] r_cmp_a;
   logic [NIB_W-1:0] r_cmp_b;
   logic             r_rsp_valid;
   logic             r_rsp_id;
   logic             r_rsp_eq;

   logic [NREQ-1:0]  w_grant;
   logic             w_idle;
   logic [OP_W-1:0]  w_sel_a;
   logic [OP_W-1:0]  w_sel_b;

   rr_arb2 u_rr_arb2 (
      .i_valid ({req1_valid, req0_valid}),
      .i_ptr   (r_ptr),
      .o_grant (w_grant)
   );

   // Ready is gated by reset so nothing can be accepted during the reset cycle.
   assign w_idle     = reset_n && (r_state == ST_IDLE);
   assign req0_ready = w_idle && w_grant[0];
   assign req1_ready = w_idle && w_grant[1];

   assign w_sel_a = w_grant[1] ? req1_a : req0_a;
   assign w_sel_b = w_grant[1] ? req1_b : req0_b;

   assign cmp_a     = r_cmp_a;
   assign cmp_b     = r_cmp_b;
   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_eq    = r_rsp_eq;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_ptr       <= 1'b0;
         r_id        <= 1'b0;
         r_hi_eq     <= 1'b0;
         r_lo_a      <= '0;
         r_lo_b      <= '0;
         r_cmp_a     <= '0;
         r_cmp_b     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= 1'b0;
         r_rsp_eq    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (|w_grant) begin
                  r_id    <= w_grant[1];
                  r_ptr   <= ~w_grant[1];
                  r_cmp_a <= w_sel_a[OP_W-1:NIB_W];
                  r_cmp_b <= w_sel_b[OP_W-1:NIB_W];
                  r_lo_a  <= w_sel_a[NIB_W-1:0];
                  r_lo_b  <= w_sel_b[NIB_W-1:0];
                  r_state <= ST_HI;
               end
            end
            ST_HI: begin
               r_hi_eq <= cmp_status;
               if (EARLY_OUT && !cmp_status) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_eq    <= 1'b0;
                  r_rsp_id    <= r_id;
                  r_cmp_a     <= '0;
                  r_cmp_b     <= '0;
                  r_state     <= ST_RESP;
               end else begin
                  r_cmp_a <= r_lo_a;
                  r_cmp_b <= r_lo_b;
                  r_state <= ST_LO;
               end
            end
            ST_LO: begin
               r_rsp_valid <= 1'b1;
               r_rsp_eq    <= r_hi_eq && cmp_status;
               r_rsp_id    <= r_id;
               r_cmp_a     <= '0;
               r_cmp_b     <= '0;
               r_state     <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench: instance 0 has early-out enabled, instance 1 always runs both nibble passes.
module tb_cmp_arbiter;
   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n [2];
   logic       v     [2][2];
   logic [7:0] a     [2][2];
   logic [7:0] b     [2][2];
   logic       rdy   [2][2];
   logic [3:0] ca    [2];
   logic [3:0] cb    [2];
   logic       cs    [2];
   logic       rv    [2];
   logic       rid   [2];
   logic       req_o [2];
   logic       rr    [2];

   int checks = 0;
   int errors = 0;

   assign cs[0] = (ca[0] == cb[0]);
   assign cs[1] = (ca[1] == cb[1]);

   cmp_arbiter #(.EARLY_OUT(1'b1)) dut_eo (
      .clk(clk), .reset_n(rst_n[0]),
      .req0_valid(v[0][0]), .req0_a(a[0][0]), .req0_b(b[0][0]), .req0_ready(rdy[0][0]),
      .req1_valid(v[0][1]), .req1_a(a[0][1]), .req1_b(b[0][1]), .req1_ready(rdy[0][1]),
      .cmp_a(ca[0]), .cmp_b(cb[0]), .cmp_status(cs[0]),
      .rsp_valid(rv[0]), .rsp_id(rid[0]), .rsp_eq(req_o[0]), .rsp_ready(rr[0])
   );

   cmp_arbiter #(.EARLY_OUT(1'b0)) dut_full (
      .clk(clk), .reset_n(rst_n[1]),
      .req0_valid(v[1][0]), .req0_a(a[1][0]), .req0_b(b[1][0]), .req0_ready(rdy[1][0]),
      .req1_valid(v[1][1]), .req1_a(a[1][1]), .req1_b(b[1][1]), .req1_ready(rdy[1][1]),
      .cmp_a(ca[1]), .cmp_b(cb[1]), .cmp_status(cs[1]),
      .rsp_valid(rv[1]), .rsp_id(rid[1]), .rsp_eq(req_o[1]), .rsp_ready(rr[1])
   );

   typedef struct {
      logic       inst;
      logic       id;
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] ha, hb, la, lb;
      logic       early;
      logic       eq;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pulse_reset(input int inst);
      @(negedge clk);
      rst_n[inst] = 1'b0;
      @(negedge clk);
      rst_n[inst] = 1'b1;
   endtask

   task automatic run_vec(input vec_t t, input int n);
      int    wn;
      int    ii;
      int    id;
      string tag;
      ii  = int'(t.inst);
      id  = int'(t.id);
      tag = $sformatf("v%0d", n);
      @(negedge clk);
      v[ii][id] = 1'b1;
      a[ii][id] = t.a;
      b[ii][id] = t.b;
      rr[ii]    = 1'b1;
      #1;
      wn = 0;
      while (!rdy[ii][id] && wn < 10) begin
         @(negedge clk);
         #1;
         wn++;
      end
      chk({tag, "_accept"}, rdy[ii][id], 1);
      @(posedge clk);
      #1;
      v[ii][id] = 1'b0;
      @(negedge clk);
      chk({tag, "_hi_a"}, ca[ii], t.ha);
      chk({tag, "_hi_b"}, cb[ii], t.hb);
      chk({tag, "_hi_rv"}, rv[ii], 0);
      chk({tag, "_hi_rdy"}, {rdy[ii][1], rdy[ii][0]}, 0);
      @(negedge clk);
      if (!t.early) begin
         chk({tag, "_lo_a"}, ca[ii], t.la);
         chk({tag, "_lo_b"}, cb[ii], t.lb);
         chk({tag, "_lo_rv"}, rv[ii], 0);
         @(negedge clk);
      end
      chk({tag, "_rsp_valid"}, rv[ii], 1);
      chk({tag, "_rsp_id"}, rid[ii], t.id);
      chk({tag, "_rsp_eq"}, req_o[ii], t.eq);
      chk({tag, "_rsp_cmp"}, {ca[ii], cb[ii]}, 0);
      @(negedge clk);
      chk({tag, "_done"}, rv[ii], 0);
      $display("TXN %s inst=%0d id=%0d a=%02h b=%02h eq=%0b early=%0b", tag, ii, id, t.a, t.b, req_o[ii], t.early);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int g [4];
      int ng;
      int last_cyc;
      int cyc;

      vecs[0] = '{1'b0, 1'b0, 8'hA5, 8'hA5, 4'hA, 4'hA, 4'h5, 4'h5, 1'b0, 1'b1};
      vecs[1] = '{1'b0, 1'b1, 8'h3C, 8'h7C, 4'h3, 4'h7, 4'h0, 4'h0, 1'b1, 1'b0};
      vecs[2] = '{1'b1, 1'b1, 8'h3C, 8'h7C, 4'h3, 4'h7, 4'hC, 4'hC, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 8'h12, 8'h13, 4'h1, 4'h1, 4'h2, 4'h3, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 1'b1, 8'hFF, 8'hFF, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 1'b1};
      vecs[5] = '{1'b1, 1'b0, 8'h00, 8'h80, 4'h0, 4'h8, 4'h0, 4'h0, 1'b0, 1'b0};
      vecs[6] = '{1'b0, 1'b0, 8'hF0, 8'hE0, 4'hF, 4'hE, 4'h0, 4'h0, 1'b1, 1'b0};

      for (int i = 0; i < 2; i++) begin
         rst_n[i] = 1'b0;
         rr[i]    = 1'b0;
         for (int j = 0; j < 2; j++) begin
            v[i][j] = 1'b0;
            a[i][j] = 8'h00;
            b[i][j] = 8'h00;
         end
      end
      v[0][0] = 1'b1; a[0][0] = 8'h11; b[0][0] = 8'h11;
      v[1][1] = 1'b1; a[1][1] = 8'h22; b[1][1] = 8'h22;
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("reset_rv%0d", i), rv[i], 0);
         chk($sformatf("reset_id%0d", i), rid[i], 0);
         chk($sformatf("reset_eq%0d", i), req_o[i], 0);
         chk($sformatf("reset_cmp%0d", i), {ca[i], cb[i]}, 0);
         chk($sformatf("reset_rdy%0d", i), {rdy[i][1], rdy[i][0]}, 0);
      end
      v[0][0] = 1'b0;
      v[1][1] = 1'b0;
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;

      for (int n = 0; n < 7; n++) begin
         run_vec(vecs[n], n);
      end

      // Both requesters continuously valid: grants must alternate starting at 0.
      pulse_reset(0);
      v[0][0] = 1'b1; a[0][0] = 8'h55; b[0][0] = 8'h55;
      v[0][1] = 1'b1; a[0][1] = 8'h55; b[0][1] = 8'h55;
      rr[0] = 1'b1;
      ng = 0; last_cyc = 0; cyc = 0;
      while (ng < 4 && cyc < 40) begin
         #1;
         if (rdy[0][0] || rdy[0][1]) begin
            chk("rr_onehot", rdy[0][0] && rdy[0][1], 0);
            chk("rr_idle_only", {ca[0], rv[0]}, 0);
            if (ng > 0) chk("rr_interval", cyc - last_cyc, 4);
            g[ng] = rdy[0][1] ? 1 : 0;
            last_cyc = cyc;
            ng++;
            $display("TXN rr grant %0d -> req%0d", ng, g[ng-1]);
         end
         @(negedge clk);
         cyc++;
      end
      chk("rr_count", ng, 4);
      @(posedge clk);
      #1;
      v[0][0] = 1'b0;
      v[0][1] = 1'b0;
      for (int k = 0; k < 4; k++) chk($sformatf("rr_grant%0d", k), g[k], k % 2);
      repeat (5) @(negedge clk);

      // Stalled response holds its fields and blocks the waiting requester.
      pulse_reset(0);
      rr[0] = 1'b0;
      v[0][0] = 1'b1; a[0][0] = 8'h12; b[0][0] = 8'h12;
      #1;
      chk("stall_accept0", rdy[0][0], 1);
      @(posedge clk);
      #1;
      v[0][0] = 1'b0;
      v[0][1] = 1'b1; a[0][1] = 8'h40; b[0][1] = 8'h41;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         chk("stall_rv", rv[0], 1);
         chk("stall_id", rid[0], 0);
         chk("stall_eq", req_o[0], 1);
         chk("stall_rdy1", rdy[0][1], 0);
         if (k < 4) @(negedge clk);
      end
      rr[0] = 1'b1;
      @(negedge clk);
      chk("stall_released_rv", rv[0], 0);
      chk("stall_rdy1_after", rdy[0][1], 1);
      @(posedge clk);
      #1;
      v[0][1] = 1'b0;
      @(negedge clk);
      chk("stall_r1_hi", {ca[0], cb[0]}, 8'h44);
      @(negedge clk);
      chk("stall_r1_lo", {ca[0], cb[0]}, 8'h01);
      @(negedge clk);
      chk("stall_r1_rv", rv[0], 1);
      chk("stall_r1_id", rid[0], 1);
      chk("stall_r1_eq", req_o[0], 0);
      $display("TXN stall sequence done");
      @(negedge clk);

      // Reset in the middle of the LO pass discards the result and resets the pointer.
      v[0][0] = 1'b1; a[0][0] = 8'h55; b[0][0] = 8'h55;
      #1;
      chk("rst_accept0", rdy[0][0], 1);
      @(posedge clk);
      #1;
      v[0][0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_in_lo", {ca[0], cb[0]}, 8'h55);
      rst_n[0] = 1'b0;
      @(negedge clk);
      v[0][0] = 1'b1;
      v[0][1] = 1'b1;
      #1;
      chk("rst_mid_rv", rv[0], 0);
      chk("rst_mid_cmp", {ca[0], cb[0]}, 0);
      chk("rst_mid_rdy", {rdy[0][1], rdy[0][0]}, 0);
      v[0][0] = 1'b0;
      v[0][1] = 1'b0;
      rst_n[0] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rst_no_rsp", rv[0], 0);
      end
      v[0][0] = 1'b1;
      v[0][1] = 1'b1;
      #1;
      chk("rst_grant0", rdy[0][0], 1);
      chk("rst_grant1", rdy[0][1], 0);
      @(posedge clk);
      #1;
      v[0][0] = 1'b0;
      v[0][1] = 1'b0;
      $display("TXN reset-in-LO sequence done");
      repeat (5) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
